// File: rtl/sar_pkg.sv
// Shared types and elaboration helpers for the parametrised SAR controller.
package sar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SAMPLE, ST_RELEASE, ST_SETTLE, ST_COMPARE, ST_DECIDE, ST_DONE
  } sar_state_e;

  // Phase counter width: enough to hold the longest timed phase.
  function automatic int cnt_width(input int sample_cyc, input int settle_cyc, input int comp_cyc);
    int m;
    m = sample_cyc;
    if (settle_cyc > m) m = settle_cyc;
    if (comp_cyc > m) m = comp_cyc;
    return $clog2(m + 1);
  endfunction

  function automatic bit params_legal(input int n_bit, input int sample_cyc,
                                      input int settle_cyc, input int comp_cyc);
    return (n_bit >= 2) && (n_bit <= 16) && (sample_cyc >= 1) &&
           (settle_cyc >= 1) && (comp_cyc >= 1);
  endfunction

endpackage

// File: rtl/sar_phase_timer.sv
// Loadable down-counter; o_tc is high while the count is zero.
module sar_phase_timer #(
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)              r_cnt <= '0;
    else if (i_load)        r_cnt <= i_val;
    else if (r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/sar_logic_param.sv
// Parametrised SAR controller: CDAC switch sequencing, START/BUSY/DONE handshake.
// Optional serial bit stream on DIGITAL_OUT/BIT_VALID when SAR_SERIAL_OUT_EN is defined.
module sar_logic_param
  import sar_pkg::*;
#(
  parameter int N_BIT      = 8,
  parameter int SAMPLE_CYC = 2,
  parameter int SETTLE_CYC = 1,
  parameter int COMP_CYC   = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             CONT,
  input  logic             COMP_OUT,
  output logic             COMP_CLK,
  output logic             SC,
  output logic [N_BIT-1:0] SDAC,
  output logic [N_BIT-1:0] DOUT,
  output logic             BUSY,
  output logic             DONE
`ifdef SAR_SERIAL_OUT_EN
  ,
  output logic             DIGITAL_OUT,
  output logic             BIT_VALID
`endif
);

  localparam int CW = cnt_width(SAMPLE_CYC, SETTLE_CYC, COMP_CYC);
  localparam int KW = $clog2(N_BIT);
  localparam logic [KW-1:0] K_TOP     = KW'(N_BIT - 1);
  localparam logic [CW-1:0] LD_SAMPLE = CW'(SAMPLE_CYC - 1);
  // DONE already drives SC=1/SDAC=0, so a restart from DONE counts it as the first sample cycle.
  localparam logic [CW-1:0] LD_RESMP  = CW'((SAMPLE_CYC > 1) ? SAMPLE_CYC - 2 : 0);
  localparam logic [CW-1:0] LD_SETTLE = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] LD_COMP   = CW'(COMP_CYC - 1);

  if (!params_legal(N_BIT, SAMPLE_CYC, SETTLE_CYC, COMP_CYC)) begin : g_bad_params
    $error("sar_logic_param: parameter out of legal range");
  end

  sar_state_e       r_state, w_nstate;
  logic [N_BIT-1:0] r_result, w_res_nxt;
  logic [KW-1:0]    r_k, w_k_nxt;
  logic             r_cont;
  logic             w_tc, w_load;
  logic [CW-1:0]    w_ld_val;
  logic             r_sc, r_comp_clk, r_busy, r_done;
  logic [N_BIT-1:0] r_sdac, r_dout;

  sar_phase_timer #(.W(CW)) u_timer (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_load (w_load),
    .i_val  (w_ld_val),
    .o_tc   (w_tc)
  );

  always_comb begin
    w_nstate  = r_state;
    w_res_nxt = r_result;
    w_k_nxt   = r_k;
    case (r_state)
      ST_IDLE: begin
        w_res_nxt = '0;
        w_k_nxt   = K_TOP;
        if (START) w_nstate = ST_SAMPLE;
      end
      ST_SAMPLE:  if (w_tc) w_nstate = ST_RELEASE;
      ST_RELEASE: w_nstate = ST_SETTLE;
      ST_SETTLE:  if (w_tc) w_nstate = ST_COMPARE;
      ST_COMPARE: if (w_tc) w_nstate = ST_DECIDE;
      ST_DECIDE: begin
        w_res_nxt[r_k] = COMP_OUT;
        if (r_k == '0) begin
          w_nstate = ST_DONE;
        end else begin
          w_nstate = ST_SETTLE;
          w_k_nxt  = r_k - 1'b1;
        end
      end
      ST_DONE: begin
        w_res_nxt = '0;
        w_k_nxt   = K_TOP;
        if (r_cont || START) w_nstate = (SAMPLE_CYC == 1) ? ST_RELEASE : ST_SAMPLE;
        else                 w_nstate = ST_IDLE;
      end
      default: w_nstate = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load = (w_nstate != r_state);
    case (w_nstate)
      ST_SAMPLE:  w_ld_val = (r_state == ST_DONE) ? LD_RESMP : LD_SAMPLE;
      ST_SETTLE:  w_ld_val = LD_SETTLE;
      ST_COMPARE: w_ld_val = LD_COMP;
      default:    w_ld_val = '0;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_result   <= '0;
      r_k        <= K_TOP;
      r_cont     <= 1'b0;
      r_sc       <= 1'b1;
      r_sdac     <= '0;
      r_comp_clk <= 1'b0;
      r_dout     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_result   <= w_res_nxt;
      r_k        <= w_k_nxt;
      if ((r_state == ST_IDLE || r_state == ST_DONE) && START) r_cont <= CONT;
      r_sc       <= (w_nstate inside {ST_IDLE, ST_SAMPLE, ST_DONE});
      r_comp_clk <= (w_nstate == ST_COMPARE);
      r_sdac     <= (w_nstate inside {ST_SETTLE, ST_COMPARE, ST_DECIDE}) ?
                    (w_res_nxt | (N_BIT'(1) << w_k_nxt)) : '0;
      r_busy     <= !(w_nstate inside {ST_IDLE, ST_DONE});
      r_done     <= (w_nstate == ST_DONE);
      if (w_nstate == ST_DONE) r_dout <= w_res_nxt;
    end
  end

  assign COMP_CLK = r_comp_clk;
  assign SC       = r_sc;
  assign SDAC     = r_sdac;
  assign DOUT     = r_dout;
  assign BUSY     = r_busy;
  assign DONE     = r_done;

`ifdef SAR_SERIAL_OUT_EN
  logic r_dig, r_bit_vld;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dig     <= 1'b0;
      r_bit_vld <= 1'b0;
    end else begin
      r_bit_vld <= (r_state == ST_DECIDE);
      if (r_state == ST_DECIDE) r_dig <= COMP_OUT;
    end
  end

  assign DIGITAL_OUT = r_dig;
  assign BIT_VALID   = r_bit_vld;
`endif

endmodule

// File: tb/tb_sar_logic_param.sv
// Self-checking bench: default 8-bit instance plus a 12-bit instance with stretched phases.
module tb_sar_logic_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, cont, comp, comp_clk, sc, busy, done, noise;
  logic [7:0] sdac, dout, vin;
  logic        start12, cont12, comp12, comp_clk12, sc12, busy12, done12;
  logic [11:0] sdac12, dout12, vin12;
`ifdef SAR_SERIAL_OUT_EN
  logic dig, bv, dig12, bv12;
`endif

  // Ideal comparator; during COMPARE its output is junk the DUT must not use.
  always @(negedge clk) noise = 1'($urandom_range(0, 1));
  assign comp   = comp_clk   ? noise : (sdac <= vin);
  assign comp12 = comp_clk12 ? noise : (sdac12 <= vin12);

  sar_logic_param dut (
    .CLK(clk), .RST(rst), .START(start), .CONT(cont), .COMP_OUT(comp),
    .COMP_CLK(comp_clk), .SC(sc), .SDAC(sdac), .DOUT(dout), .BUSY(busy), .DONE(done)
`ifdef SAR_SERIAL_OUT_EN
    , .DIGITAL_OUT(dig), .BIT_VALID(bv)
`endif
  );

  sar_logic_param #(.N_BIT(12), .SAMPLE_CYC(4), .SETTLE_CYC(2), .COMP_CYC(3)) dut12 (
    .CLK(clk), .RST(rst), .START(start12), .CONT(cont12), .COMP_OUT(comp12),
    .COMP_CLK(comp_clk12), .SC(sc12), .SDAC(sdac12), .DOUT(dout12), .BUSY(busy12), .DONE(done12)
`ifdef SAR_SERIAL_OUT_EN
    , .DIGITAL_OUT(dig12), .BIT_VALID(bv12)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int exp_latency(input int n, input int s, input int se, input int c);
    return s + 1 + n * (se + c + 1) + 1;
  endfunction

  // Binary search trial i keeps the bits of vin above bit k and probes bit k.
  function automatic int trial_code(input int v, input int n, input int i);
    int k;
    k = n - 1 - i;
    return ((v >> (k + 1)) << (k + 1)) | (1 << k);
  endfunction

  typedef struct {
    logic [7:0] vin;
    logic [7:0] exp_dout;
    int         exp_lat;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] trials[$];

  task automatic do_conv8(input logic [7:0] v, input logic [7:0] exp_d, input int exp_l);
    int n, w;
    bit prev, got;
    trials.delete();
    @(negedge clk);
    vin = v; start = 1'b1; cont = 1'b0;
    n = 0; w = 0; prev = 0; got = 0;
    while (!got && n < 100) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (comp_clk) begin
        if (!prev) trials.push_back(sdac);
        w++;
      end else if (prev) begin
        chk("comp_clk_width", w, 1);
        w = 0;
      end
      prev = comp_clk;
      if (done) got = 1;
    end
    chk("latency8", n, exp_l);
    chk("dout8", dout, exp_d);
    chk("trial_count8", trials.size(), 8);
    foreach (trials[i]) chk("trial8", trials[i], trial_code(int'(v), 8, i));
    @(posedge clk); #1;
    chk("done_pulse_width", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_sc", sc, 1);
  endtask

  task automatic do_conv12(input logic [11:0] v);
    int n, w;
    bit prev, got;
    logic bits[$];
    @(negedge clk);
    vin12 = v; start12 = 1'b1; cont12 = 1'b0;
    n = 0; w = 0; prev = 0; got = 0;
    while (!got && n < 200) begin
      @(posedge clk); #1;
      n++;
      start12 = 1'b0;
      if (comp_clk12) w++;
      else if (prev) begin
        chk("comp_clk_width12", w, 3);
        w = 0;
      end
      prev = comp_clk12;
`ifdef SAR_SERIAL_OUT_EN
      if (bv12) bits.push_back(dig12);
`endif
      if (done12) got = 1;
    end
    chk("latency12", n, exp_latency(12, 4, 2, 3));
    chk("dout12", dout12, v);
`ifdef SAR_SERIAL_OUT_EN
    chk("serial_count12", bits.size(), 12);
    foreach (bits[i]) chk("serial_bit12", bits[i], v[11-i]);
`endif
    @(posedge clk); #1;
    chk("idle12_busy", busy12, 0);
    chk("idle12_sc", sc12, 1);
    chk("idle12_done", done12, 0);
  endtask

  initial begin
    int n, nd, extra;
    bit prev, hit;
    int t[$];
    logic [7:0] rv;

    rst = 1'b1; start = 1'b0; cont = 1'b0; vin = '0;
    start12 = 1'b0; cont12 = 1'b0; vin12 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sc", sc, 1);
    chk("rst_sdac", sdac, 0);
    chk("rst_comp_clk", comp_clk, 0);
    chk("rst_dout", dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    tbl.push_back(vec_t'{8'hA5, 8'hA5, 28});
    tbl.push_back(vec_t'{8'h00, 8'h00, 28});
    tbl.push_back(vec_t'{8'hFF, 8'hFF, 28});
    tbl.push_back(vec_t'{8'h01, 8'h01, 28});
    tbl.push_back(vec_t'{8'h80, 8'h80, 28});
    tbl.push_back(vec_t'{8'h7F, 8'h7F, 28});
    // An ideal comparator makes the result the largest code not above vin, i.e. vin.
    for (int i = 0; i < 6; i++) begin
      rv = 8'($urandom_range(0, 255));
      tbl.push_back(vec_t'{rv, rv, exp_latency(8, 2, 1, 1)});
    end
    foreach (tbl[i]) do_conv8(tbl[i].vin, tbl[i].exp_dout, tbl[i].exp_lat);

    // Continuous mode, with START pulses while busy and CONT dropped after the first edge.
    @(negedge clk);
    vin = 8'h3C; start = 1'b1; cont = 1'b1;
    n = 0;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0; cont = 1'b0;
      if (done) begin
        t.push_back(n);
        chk("cont_dout", dout, (t.size() <= 2) ? 8'h3C : 8'hC3);
        if (t.size() == 2) vin = 8'hC3;
        if (t.size() == 3) start = 1'b1;
      end
      if (n == 10 || n == 40) start = 1'b1;
    end
    chk("cont_done_count", t.size(), 4);
    if (t.size() >= 4) begin
      chk("cont_first_latency", t[0], 28);
      chk("cont_period_1", t[1] - t[0], 27);
      chk("cont_period_2", t[2] - t[1], 27);
      chk("cont_period_3", t[3] - t[2], 27);
    end
    chk("cont_exit_busy", busy, 0);

    // Reset during the 4th DECIDE cycle.
    @(negedge clk);
    vin = 8'h5A; start = 1'b1; cont = 1'b0;
    n = 0; nd = 0; prev = 0; hit = 0;
    while (!hit && n < 100) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (!comp_clk && prev) begin
        nd++;
        if (nd == 4) hit = 1;
      end
      prev = comp_clk;
    end
    chk("rst_mid_reached", hit, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_sc", sc, 1);
    chk("rst_mid_sdac", sdac, 0);
    chk("rst_mid_dout", dout, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    rst = 1'b0;
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    chk("rst_mid_stays_idle", extra, 0);

    do_conv12(12'h5A3);
    do_conv12(12'($urandom_range(0, 4095)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
